// File: rtl/sfu_rmw.sv
// sfu_rmw: special-function read-modify-write stage between the output
// FIFO and the partial-sum memory (accumulate, load, ReLU, acc+ReLU).
module sfu_rmw #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int addr_bw = 11,
   parameter bit sat     = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [1:0]               mode,
   input  logic [addr_bw-1:0]       base_addr,
   input  logic [addr_bw:0]         len,
   output logic                     busy,
   output logic                     done,
   output logic                     ovf,
   input  logic [col*psum_bw-1:0]   ofifo_out,
   input  logic                     ofifo_valid,
   output logic                     ofifo_rd,
   output logic                     psum_mem_rd,
   output logic [addr_bw-1:0]       psum_mem_raddr,
   input  logic [col*psum_bw-1:0]   psum_mem_dout,
   output logic                     psum_mem_wr,
   output logic [addr_bw-1:0]       psum_mem_waddr,
   output logic [col*psum_bw-1:0]   psum_mem_din
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [1:0] M_ACC  = 2'b00;
   localparam logic [1:0] M_LOAD = 2'b01;
   localparam logic [1:0] M_RELU = 2'b10;
   localparam logic [1:0] M_ACCR = 2'b11;
   localparam int VW = col * psum_bw;
   localparam logic [psum_bw-1:0] SMAX = {1'b0, {(psum_bw-1){1'b1}}};
   localparam logic [psum_bw-1:0] SMIN = {1'b1, {(psum_bw-1){1'b0}}};

   state_t             state;
   logic [1:0]         mode_r;
   logic [addr_bw-1:0] base_r;
   logic [addr_bw:0]   len_r;
   logic [addr_bw:0]   cnt;
   logic               s1_valid;
   logic [addr_bw-1:0] s1_addr;
   logic [VW-1:0]      s1_f;
   logic               issue;
   logic               last;
   logic               acc_mode;
   logic [VW-1:0]      res;
   logic               lane_ovf;
   logic [psum_bw-1:0] d, f, acc, r;
   logic [psum_bw:0]   s;
   logic               lo;

   assign issue    = (state == RUN) && ((mode_r == M_RELU) || ofifo_valid);
   assign last     = (cnt == len_r - 1'b1);
   assign acc_mode = (mode_r == M_ACC) || (mode_r == M_ACCR);

   assign ofifo_rd       = issue && (mode_r != M_RELU);
   assign psum_mem_rd    = issue && (mode_r != M_LOAD);
   assign psum_mem_raddr = base_r + cnt[addr_bw-1:0];

   // Per-lane math: sign-extended sum, overflow from the two top bits.
   always_comb begin
      res      = '0;
      lane_ovf = 1'b0;
      d        = '0;
      f        = '0;
      s        = '0;
      lo       = 1'b0;
      acc      = '0;
      r        = '0;
      for (int i = 0; i < col; i++) begin
         d   = psum_mem_dout[i*psum_bw +: psum_bw];
         f   = s1_f[i*psum_bw +: psum_bw];
         s   = {d[psum_bw-1], d} + {f[psum_bw-1], f};
         lo  = s[psum_bw] != s[psum_bw-1];
         acc = (lo && sat) ? (s[psum_bw] ? SMIN : SMAX)
                           : s[psum_bw-1:0];
         unique case (mode_r)
            M_LOAD:  r = f;
            M_RELU:  r = d[psum_bw-1] ? '0 : d;
            M_ACCR:  r = acc[psum_bw-1] ? '0 : acc;
            default: r = acc;
         endcase
         if (lo && acc_mode) lane_ovf = 1'b1;
         res[i*psum_bw +: psum_bw] = r;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         mode_r         <= M_ACC;
         base_r         <= '0;
         len_r          <= '0;
         cnt            <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         ovf            <= 1'b0;
         s1_valid       <= 1'b0;
         s1_addr        <= '0;
         s1_f           <= '0;
         psum_mem_wr    <= 1'b0;
         psum_mem_waddr <= '0;
         psum_mem_din   <= '0;
      end else begin
         done        <= 1'b0;
         s1_valid    <= issue;
         psum_mem_wr <= s1_valid;
         if (issue) begin
            s1_addr <= psum_mem_raddr;
            s1_f    <= ofifo_out;
            cnt     <= cnt + 1'b1;
         end
         if (s1_valid) begin
            psum_mem_waddr <= s1_addr;
            psum_mem_din   <= res;
            if (lane_ovf) ovf <= 1'b1;
         end
         unique case (state)
            IDLE: if (start) begin
               mode_r <= mode;
               base_r <= base_addr;
               len_r  <= len;
               cnt    <= '0;
               ovf    <= 1'b0;
               busy   <= 1'b1;
               state  <= (len == '0) ? DONE : RUN;
            end
            RUN: if (issue && last) state <= DRAIN;
            // Last issue sits in stage 1; its write lands during DONE.
            DRAIN: state <= DONE;
            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
